// File: rtl/rx78_keyboard_if.sv
// CPU-side I/O port bundle for the RX-78 keyboard at port F4.
// The master drives select/write/data; the slave returns the row read data.
interface rx78_keyboard_if;
    logic       io_sel;
    logic       io_wr;
    logic [7:0] din;
    logic [7:0] dout;

    modport master (output io_sel, output io_wr, output din, input dout);
    modport slave  (input io_sel, input io_wr, input din, output dout);
endinterface

// File: rtl/rx78_keyboard.sv
// PS/2 Set-2 receiver and decoder that maintains the RX-78 9x8 key matrix.
// The CPU selects a row by writing port F4 and reads that row back from the same port.
module rx78_keyboard #(
    parameter int FILT_CYCLES = 8,
    parameter int TIMEOUT     = 20000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    rx78_keyboard_if.slave   bus,
    output logic             key_strobe,
    output logic             frame_err
);
    localparam int FW = $clog2(FILT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Result packing: {hit, row[3:0], col[2:0]}.
    function automatic logic [7:0] key_map(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h016:  key_map = {1'b1, 4'd0, 3'd1};
            9'h01E:  key_map = {1'b1, 4'd0, 3'd2};
            9'h01C:  key_map = {1'b1, 4'd2, 3'd1};
            9'h032:  key_map = {1'b1, 4'd2, 3'd2};
            9'h021:  key_map = {1'b1, 4'd2, 3'd3};
            9'h05A:  key_map = {1'b1, 4'd7, 3'd0};
            9'h029:  key_map = {1'b1, 4'd7, 3'd1};
            9'h076:  key_map = {1'b1, 4'd7, 3'd2};
            9'h066:  key_map = {1'b1, 4'd7, 3'd3};
            9'h012:  key_map = {1'b1, 4'd8, 3'd0};
            9'h059:  key_map = {1'b1, 4'd8, 3'd0};
            9'h175:  key_map = {1'b1, 4'd6, 3'd0};
            9'h172:  key_map = {1'b1, 4'd6, 3'd1};
            9'h16B:  key_map = {1'b1, 4'd6, 3'd2};
            9'h174:  key_map = {1'b1, 4'd6, 3'd3};
            default: key_map = 8'h00;
        endcase
    endfunction

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        odd_parity_ok = ^{data, par};
    endfunction

    logic            ps2c_s1_q, ps2c_s2_q, ps2d_s1_q, ps2d_s2_q;
    logic            filt_q, filt_d;
    logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
    logic            fall_s;
    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            byte_valid_s, ferr_s;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic [8:0][7:0] matrix_q, matrix_d;
    logic [7:0]      map_s;
    logic [3:0]      row_sel_q, row_sel_d;
    logic [7:0]      dout_q, dout_d;
    logic            key_strobe_q, key_strobe_d;
    logic            frame_err_q;

    // Glitch filter: the level only follows after FILT_CYCLES consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (ps2c_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILT_CYCLES - 1)) begin
                filt_d     = ps2c_s2_q;
                filt_cnt_d = '0;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end else begin
            filt_cnt_d = '0;
        end
        fall_s = filt_q & ~filt_d;
    end

    // Frame receiver: start, 8 data bits LSB first, odd parity, stop, with inter-edge timeout.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_s = 1'b0;
        ferr_s       = 1'b0;
        if (fall_s) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!ps2d_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {ps2d_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_d   = ps2d_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (ps2d_s2_q && odd_parity_ok(shift_q, par_q)) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                state_d  = ST_IDLE;
                to_cnt_d = '0;
                ferr_s   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Scan-code decoder: prefixes latch, status bytes clear, mapped keys update the matrix.
    always_comb begin
        ext_d        = ext_q;
        brk_d        = brk_q;
        matrix_d     = matrix_q;
        key_strobe_d = 1'b0;
        map_s        = key_map(ext_q, shift_q);
        if (byte_valid_s) begin
            case (shift_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                    // A bit equal to brk means it differs from the target ~brk.
                    if (map_s[7] && (matrix_q[map_s[6:3]][map_s[2:0]] == brk_q)) begin
                        matrix_d[map_s[6:3]][map_s[2:0]] = ~brk_q;
                        key_strobe_d                     = 1'b1;
                    end else begin
                        key_strobe_d = 1'b0;
                    end
                end
            endcase
        end else begin
            key_strobe_d = 1'b0;
        end
    end

    // CPU port: row select on write, registered row data on read, zero otherwise.
    always_comb begin
        if (bus.io_sel && bus.io_wr) begin
            row_sel_d = bus.din[3:0];
        end else begin
            row_sel_d = row_sel_q;
        end
        if (bus.io_sel && !bus.io_wr && (row_sel_q <= 4'd8)) begin
            dout_d = matrix_q[row_sel_q];
        end else begin
            dout_d = 8'h00;
        end
    end

    // State registers; synchronizers and the filtered clock rest at the idle-high level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2c_s1_q    <= 1'b1;
            ps2c_s2_q    <= 1'b1;
            ps2d_s1_q    <= 1'b1;
            ps2d_s2_q    <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            matrix_q     <= '0;
            row_sel_q    <= 4'd0;
            dout_q       <= 8'h00;
            key_strobe_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            ps2c_s1_q    <= ps2_clk;
            ps2c_s2_q    <= ps2c_s1_q;
            ps2d_s1_q    <= ps2_data;
            ps2d_s2_q    <= ps2d_s1_q;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            matrix_q     <= matrix_d;
            row_sel_q    <= row_sel_d;
            dout_q       <= dout_d;
            key_strobe_q <= key_strobe_d;
            frame_err_q  <= ferr_s;
        end
    end

    assign bus.dout   = dout_q;
    assign key_strobe = key_strobe_q;
    assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_rx78_keyboard.sv
// Directed bench for rx78_keyboard: a byte-level key-matrix model drives a per-cycle
// dout comparison, and pulse counts plus literal row reads pin the model.
module tb_rx78_keyboard;
    localparam int FILT = 8;
    localparam int TMO  = 200;
    localparam int HALF = 20;

    logic clk      = 1'b0;
    logic reset_n  = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic key_strobe, frame_err;

    rx78_keyboard_if bus_if ();

    rx78_keyboard #(.FILT_CYCLES(FILT), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .bus        (bus_if.slave),
        .key_strobe (key_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: key matrix, prefix flags, expected pulse totals.
    logic [7:0] mx [0:8];
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    int         exp_strobes = 0;
    int         exp_ferr    = 0;
    int         strobe_cnt  = 0;
    int         ferr_cnt    = 0;
    logic [3:0] m_row_sel;
    logic [7:0] exp_dout;
    bit         cmp_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Key position as row*8+col, or -1 when the code is not a key.
    function automatic int mlook(input bit e, input logic [7:0] c);
        if (!e) begin
            case (c)
                8'h1C: return 2 * 8 + 1;
                8'h32: return 2 * 8 + 2;
                8'h16: return 0 * 8 + 1;
                8'h5A: return 7 * 8 + 0;
                8'h29: return 7 * 8 + 1;
                8'h12, 8'h59: return 8 * 8 + 0;
                default: return -1;
            endcase
        end else begin
            case (c)
                8'h75: return 6 * 8 + 0;
                8'h72: return 6 * 8 + 1;
                default: return -1;
            endcase
        end
    endfunction

    task automatic apply_byte(input logic [7:0] b);
        int idx;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!(b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
                idx = mlook(m_ext, b);
                if (idx >= 0 && mx[idx / 8][idx % 8] != !m_brk) begin
                    mx[idx / 8][idx % 8] = !m_brk;
                    exp_strobes++;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 9; r++) mx[r] = 8'h00;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // Expected dout: registered row of the model on a read, zero on any other cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_dout  <= 8'h00;
            m_row_sel <= 4'd0;
        end else begin
            if (bus_if.io_sel && bus_if.io_wr) m_row_sel <= bus_if.din[3:0];
            exp_dout <= (bus_if.io_sel && !bus_if.io_wr && m_row_sel <= 4'd8) ? mx[m_row_sel] : 8'h00;
        end
    end

    // Per-cycle compare of dout and pulse counting, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("dout_cycle", int'(bus_if.dout), int'(exp_dout));
            if (key_strobe) strobe_cnt++;
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~^b;
        if (bad_par) p = ~p;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(p);
        send_bit(1'b1);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        if (!bad_par) apply_byte(b);
    endtask

    task automatic wr_row(input logic [7:0] v);
        @(negedge clk);
        bus_if.io_sel = 1'b1;
        bus_if.io_wr  = 1'b1;
        bus_if.din    = v;
        @(negedge clk);
        bus_if.io_sel = 1'b0;
        bus_if.io_wr  = 1'b0;
    endtask

    task automatic rd_row(input string nm, input logic [7:0] exp);
        @(negedge clk);
        bus_if.io_sel = 1'b1;
        bus_if.io_wr  = 1'b0;
        @(negedge clk);
        bus_if.io_sel = 1'b0;
        chk(nm, int'(bus_if.dout), int'(exp));
    endtask

    initial begin
        bus_if.io_sel = 1'b0;
        bus_if.io_wr  = 1'b0;
        bus_if.din    = 8'h00;
        model_reset();
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clk);
        chk("reset_dout", int'(bus_if.dout), 0);
        chk("reset_strobe", int'(key_strobe), 0);
        chk("reset_ferr", int'(frame_err), 0);

        // Make then break of 'A'.
        send_frame(8'h1C, 1'b0);
        wr_row(8'h02);
        rd_row("make_A_row2", 8'h02);
        chk("make_A_strobes", strobe_cnt, 1);
        chk("make_A_model_strobes", strobe_cnt, exp_strobes);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        rd_row("break_A_row2", 8'h00);
        chk("break_A_strobes", strobe_cnt, 2);

        // Extended Up plus L-Shift, then plain 75 misses.
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        send_frame(8'h12, 1'b0);
        wr_row(8'h06);
        rd_row("up_row6", 8'h01);
        wr_row(8'h08);
        rd_row("shift_row8", 8'h01);
        send_frame(8'h75, 1'b0);
        wr_row(8'h06);
        rd_row("plain75_row6", 8'h01);
        chk("combo_strobes", strobe_cnt, 4);

        // Bad parity frame is dropped.
        send_frame(8'h1C, 1'b1);
        exp_ferr++;
        chk("badpar_ferr", ferr_cnt, 1);
        wr_row(8'h02);
        rd_row("badpar_row2", 8'h00);
        chk("badpar_strobes", strobe_cnt, 4);

        // Timeout on a partial frame, then a good Enter.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (TMO + 60) @(negedge clk);
        exp_ferr++;
        chk("timeout_ferr", ferr_cnt, 2);
        send_frame(8'h5A, 1'b0);
        wr_row(8'h07);
        rd_row("enter_row7", 8'h01);

        // Out-of-range row and idle zero.
        wr_row(8'h0C);
        rd_row("row12_zero", 8'h00);
        wr_row(8'h06);
        rd_row("row6_again", 8'h01);
        @(negedge clk);
        chk("idle_dout", int'(bus_if.dout), 0);

        // Hold 'A', then a short glitch must not create an edge.
        send_frame(8'h1C, 1'b0);
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILT - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4 * FILT) @(negedge clk);
        chk("glitch_ferr", ferr_cnt, 2);
        chk("glitch_strobes", strobe_cnt, 6);
        wr_row(8'h02);
        rd_row("glitch_row2", 8'h02);

        // Reset in the middle of a frame clears everything without pulses.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        ps2_data = 1'b1;
        reset_n  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_mid_ferr", int'(frame_err), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int r = 0; r < 9; r++) begin
            wr_row(8'(r));
            rd_row("post_reset_row", 8'h00);
        end
        chk("final_ferr", ferr_cnt, exp_ferr);
        chk("final_strobes", strobe_cnt, exp_strobes);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rx78_keyboard.md
# rx78_keyboard

PS/2 keyboard front end for the RX-78 core, sitting directly upstream of the CPU I/O read path at port `F4`. It receives PS/2 frames, decodes Set-2 make/break/extended scan codes, and maintains a 9-row × 8-column key matrix. The CPU selects a row by writing port `F4` and reads that row's pressed-key bits from the same port, replacing the constant `00` currently returned there.

## Interface
Parameters:
- `FILT_CYCLES`, default 8: consecutive identical `clk` samples required before a synchronized `ps2_clk` level is accepted.
- `TIMEOUT`, default 20000: number of `clk` cycles without an accepted falling edge that aborts a partial frame.

Ports:
- `clk` in 1: system clock, the same as the CPU clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` in 1: raw PS/2 data, asynchronous to `clk`.
- `io_sel` in 1: I/O cycle to address low byte `F4`. This is driven by the top level as `~iorq_n && addr[7:0]==8'hF4`.
- `io_wr` in 1: high for an I/O write, low for an I/O read.
- `din` in 8: CPU write data.
- `dout` out 8: row read data, active-high (1 = pressed).
- `key_strobe` out 1: one-cycle pulse whenever a mapped key changes state.
- `frame_err` out 1: one-cycle pulse when a frame is dropped.

## Operation
- **Input conditioning**
  - Both PS/2 lines pass through a 2-flop synchronizer.
  - `ps2_clk` is then filtered: the filtered level changes only after `FILT_CYCLES` consecutive equal samples.
  - An accepted falling edge is a filtered 1→0 transition. `ps2_data` is sampled (synchronized value) in that same cycle.
- **Receiver FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: on an edge, if data=0 go to DATA with bit count 0; if data=1 stay in IDLE and pulse `frame_err`.
  - DATA: shift bits in LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: require stop=1 and odd parity over data+parity. If both hold, emit byte-valid for 1 cycle; otherwise pulse `frame_err`. Return to IDLE in either case.
  - Timeout: in any state other than IDLE, a timeout counter reaching `TIMEOUT` returns the FSM to IDLE and pulses `frame_err`. The counter clears on every accepted edge.
- **Decoder**, acting on byte-valid in the same cycle:
  - `E0` sets `ext`.
  - `F0` sets `brk`.
  - `AA`, `FA`, `EE`, `FE`, `00`, `FF`: clear `ext` and `brk`; the matrix is unchanged.
  - Any other byte: look up (`ext`, code) → (row 0–8, col 0–7, hit), then clear `ext` and `brk`.
    - On hit: set `matrix[row][col]` to `~brk` and pulse `key_strobe` if the bit changed.
    - On miss: no matrix change.
- **Fixed map entries** (the remaining map lives in the same combinational function, owned by this block):
  - `1C` 'A' → row 2 col 1
  - `32` 'B' → row 2 col 2
  - `16` '1' → row 0 col 1
  - `5A` Enter → row 7 col 0
  - `29` Space → row 7 col 1
  - `12` L-Shift and `59` R-Shift → row 8 col 0
  - `E0 75` Up → row 6 col 0
  - `E0 72` Down → row 6 col 1
- **CPU port**
  - Write (`io_sel && io_wr`): `row_sel <= din[3:0]`.
  - Read (`io_sel && !io_wr`): `dout` next cycle = `matrix[row_sel]` if `row_sel` ≤ 8, else `00`.
  - `dout` is `00` in every cycle not following a read.

## Timing
- Reset values:
  - Outputs: `dout`=00, `key_strobe`=0, `frame_err`=0.
  - Internal state: matrix all 0, `row_sel`=0, FSM=IDLE, `ext`=`brk`=0, synchronizers=1, filtered clock=1.
- Edge latency: a `ps2_clk` fall is accepted 2 (sync) + `FILT_CYCLES` cycles after the pin changes.
- Matrix update and `key_strobe` are registered 1 cycle after the accepted stop-bit edge.
- Read latency: 1 cycle. `dout` is registered from the current matrix, so an update in cycle N is visible to a read issued in cycle N+1.
- A write and a read of `F4` cannot coincide. A matrix update coinciding with a read returns the pre-update value.
- Glitches on `ps2_clk` shorter than `FILT_CYCLES` produce no edge.
- `reset_n` asserted mid-frame aborts the frame and clears all state immediately; no pulses are produced.
- Multiple simultaneous pressed keys are independent bits; there is no ghosting logic.

## Test plan
- **Make/break:** reset; send frame `1C`; write `F4`=02; read `F4` → `02`, with `key_strobe` pulsing once. Then send `F0 1C`; read → `00`.
- **Extended and combination:** send `E0 75` plus `12`; row 6 reads `01`, row 8 reads `01`. Then send plain `75` (unmapped without E0); row 6 still reads `01`.
- **Bad parity:** send `1C` with even parity → `frame_err` pulses 1 cycle; row 2 reads `00`; `key_strobe` stays 0.
- **Timeout:** send start + 4 data bits, then idle `TIMEOUT` cycles → `frame_err` pulses. A subsequent good `5A` frame gives row 7 = `01`.
- **Out-of-range and idle:** write `F4`=0C; read → `00` even with keys held. `dout` is `00` on cycles with no read.
- **Reset and glitch:** hold `1C`; pulse `ps2_clk` low for `FILT_CYCLES-1` cycles → no state change. Assert `reset_n`=0 mid-frame → all rows read `00` after release.
